serial_subtractor8b: RTL
========================

Name: serial_subtractor8b

Overview:
- Bit-serial WIDTH-bit subtractor computing D = A − B − Bin, one bit per clock, using a single full-subtractor cell and a borrow flip-flop.
- Inverse-direction companion to the team's ripple full_adder8b.
- Intended for area-constrained datapaths where a multi-cycle subtract is acceptable.
- Uses a start/busy/done handshake toward the controlling FSM.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request; operands sampled when accepted
- A  input  WIDTH  minuend
- B  input  WIDTH  subtrahend
- Bin  input  1  borrow in
- D  output  WIDTH  difference, registered
- Bout  output  1  borrow out, registered
- busy  output  1  high while a subtraction is in progress
- done  output  1  one-cycle pulse when D/Bout become valid

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; D=0, Bout=0, busy=0, done=0.
  - Internal shift registers, borrow FF and bit counter are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge latches A, B and Bin (Bin into the borrow FF), clears the counter, and moves to RUN.
  - busy=1 from the next cycle.
- RUN, on each edge:
  - Take LSBs a and b of the operand shift registers.
  - d = a^b^br; br_next = (~a&b) | (~(a^b)&br).
  - Shift d into the result register from the MSB side (right shift).
  - Shift the operand registers right.
  - Increment the counter.
  - After the WIDTH-th RUN edge: D ← result, Bout ← br_next, go to DONE.
- DONE:
  - done=1 and busy=0 for exactly this one cycle.
  - Next state is IDLE, or RUN if start=1 (back-to-back accept; new operands latched at that edge).
- Latency: start sampled at edge k → done high during the cycle after edge k+WIDTH. Throughput is one result per WIDTH+1 cycles.
- D and Bout hold their value until the next completion or reset; they do not change during RUN.
- start while busy=1 is ignored; it is not queued.
- Changes on A, B and Bin after acceptance have no effect.
- Arithmetic is modulo 2^WIDTH. Bout=1 iff A < B+Bin (unsigned).
- Reset asserted mid-RUN aborts immediately, zeroes all outputs, and produces no done pulse.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- When defined:
  - Adds output port OVF (1 bit, registered, reset 0).
  - Updated together with D as signed two's-complement overflow: (A[MSB]≠B[MSB]) && (D[MSB]≠A[MSB]), using the latched operands.
  - Holds like D.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- A=0x00, B=0x00, Bin=0, start pulse → done after 9 cycles, D=0x00, Bout=0.
- A=0x00, B=0x01, Bin=0 → D=0xFF, Bout=1 (OVF=0 if enabled). Then A=0x00, B=0x00, Bin=1 → D=0xFF, Bout=1.
- A=0xAA, B=0x55, Bin=1 → D=0x54, Bout=0. A=0x80, B=0x01, Bin=0 → D=0x7F, Bout=0, OVF=1 when SERIAL_SUB_OVF_EN is defined.
- Start A=0xF0, B=0x0F; at cycle 3 of RUN pulse start with A=0x11, B=0x11 → second request ignored; D=0xE1, Bout=0, exactly one done pulse.
- Start A=0x10, B=0x01; assert rst in cycle 4 of RUN → D=0, Bout=0, busy=0, no done. After release, a new start A=0x10, B=0x01 → D=0x0F.
- Back-to-back: start held high through the DONE cycle with new operands A=0x05, B=0x07 → second result D=0xFE, Bout=1, done pulses spaced WIDTH+1 cycles apart.

Source files
------------

// File: rtl/serial_subtractor8b.sv
// rtl/serial_subtractor8b.sv - bit-serial WIDTH-bit subtractor D = A - B - Bin
//
// Computes one difference bit per clock using a single full-subtractor cell
// and a borrow flip-flop. A start/busy/done handshake talks to the
// controlling FSM.
//
// Optional feature: define SERIAL_SUB_OVF_EN to add the signed overflow
// output OVF.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset
//   start - request; A, B and Bin are sampled when it is accepted
//   A     - minuend (WIDTH bits)
//   B     - subtrahend (WIDTH bits)
//   Bin   - borrow in
//   D     - difference, registered, holds until next completion
//   Bout  - borrow out, registered, holds until next completion
//   busy  - high while a subtraction is in progress
//   done  - one-cycle pulse when D/Bout become valid
//   OVF   - signed overflow (only with SERIAL_SUB_OVF_EN)
module serial_subtractor8b #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
`ifdef SERIAL_SUB_OVF_EN
  output logic             OVF,
`endif
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Holds the WIDTH-1 bits produced so far; the final bit joins them
  // directly on the completing edge.
  logic [WIDTH-2:0] res_sr;
  logic             br;
  logic [CNT_W-1:0] cnt;

  logic             bit_a, bit_b, bit_d, br_next, last_bit, accept;
  logic [WIDTH-1:0] res_cat;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb, b_msb;
`endif

  // Full-subtractor cell.
  assign bit_a    = a_sr[0];
  assign bit_b    = b_sr[0];
  assign bit_d    = bit_a ^ bit_b ^ br;
  assign br_next  = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br);
  assign res_cat  = {bit_d, res_sr};
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  // start is only honoured when not busy; DONE allows back-to-back accept.
  assign accept   = start && (state != RUN);

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      D      <= '0;
      Bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      OVF    <= 1'b0;
`endif
    end else if (accept) begin
      a_sr  <= A;
      b_sr  <= B;
      br    <= Bin;
      cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb <= A[WIDTH-1];
      b_msb <= B[WIDTH-1];
`endif
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_cat[WIDTH-1:1];
      br     <= br_next;
      cnt    <= cnt + CNT_W'(1);
      if (last_bit) begin
        D    <= res_cat;
        Bout <= br_next;
`ifdef SERIAL_SUB_OVF_EN
        // bit_d here is the MSB of the final difference.
        OVF  <= (a_msb != b_msb) && (bit_d != a_msb);
`endif
      end
    end
  end

endmodule
